// File: rtl/recfntorawfn_mixed.sv
// Two-stage unpacker from a recoded container float to raw fields, with per-word mid/full precision.
// Mid-precision words are checked for exact mid representability and their exponent is rebiased back to mid.
module recfntorawfn_mixed #(
    parameter int midExpWidth = 8,
    parameter int midSigWidth = 24,
    parameter int outExpWidth = 11,
    parameter int outSigWidth = 53
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_precision,
    input  logic [outExpWidth+outSigWidth:0]  in_rec,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_precision,
    output logic                              out_isNaN,
    output logic                              out_isSigNaN,
    output logic                              out_isInf,
    output logic                              out_isZero,
    output logic                              out_sign,
    output logic [outExpWidth+1:0]            out_sExp,
    output logic [outSigWidth:0]              out_sig,
    output logic                              out_notMid
);
    localparam int REC_W    = outExpWidth + outSigWidth + 1;
    localparam int EXP_W    = outExpWidth + 2;
    localparam int PAD_W    = outSigWidth - midSigWidth;
    localparam int BIAS_ADJ = (1 << outExpWidth) - (1 << midExpWidth);

    localparam logic signed [EXP_W-1:0] M_MIN      = EXP_W'((1 << (midExpWidth - 1)) + 3 - midSigWidth);
    localparam logic signed [EXP_W-1:0] M_MAX      = EXP_W'((3 << (midExpWidth - 1)) - 1);
    localparam logic        [EXP_W-1:0] EXP_INF    = EXP_W'(3 << (midExpWidth - 1));
    localparam logic        [EXP_W-1:0] EXP_NAN    = EXP_W'(7 << (midExpWidth - 2));
    localparam logic        [EXP_W-1:0] BIAS_ADJ_V = EXP_W'(BIAS_ADJ);

    logic             armed;
    logic             v1;
    logic             v2;
    logic             en1;
    logic             en2;
    logic             p1;
    logic [REC_W-1:0] rec1;

    assign en2       = !v2 || out_ready;
    assign en1       = !v1 || en2;
    assign in_ready  = armed && en1;
    assign out_valid = v2;

    logic                      sign1;
    logic [outExpWidth:0]      e1;
    logic [outSigWidth-2:0]    f1;
    logic [2:0]                c1;
    logic signed [EXP_W-1:0]   m1;
    logic                      mid_ok;

    assign sign1  = rec1[REC_W-1];
    assign e1     = rec1[REC_W-2 -: outExpWidth+1];
    assign f1     = rec1[outSigWidth-2:0];
    assign c1     = e1[outExpWidth -: 3];
    // Exponent math at EXP_W signed bits so the range test cannot wrap.
    assign m1     = $signed({1'b0, e1}) - $signed(BIAS_ADJ_V);
    assign mid_ok = (f1[PAD_W-1:0] == '0) && (m1 >= M_MIN) && (m1 <= M_MAX);

    logic                   d_nan;
    logic                   d_snan;
    logic                   d_inf;
    logic                   d_zero;
    logic                   d_sign;
    logic [EXP_W-1:0]       d_sexp;
    logic [outSigWidth:0]   d_sig;
    logic                   d_notmid;

    always_comb begin
        d_zero   = (c1 == 3'b000);
        d_inf    = (c1 == 3'b110);
        d_nan    = (c1 == 3'b111);
        d_snan   = d_nan && !f1[outSigWidth-2];
        d_sign   = sign1;
        d_sig    = {1'b0, !d_zero, f1};
        d_sexp   = {1'b0, e1};
        d_notmid = 1'b0;
        if (!p1) begin
            if (d_zero) begin
                d_sexp = '0;
            end else if (d_inf) begin
                d_sexp = EXP_INF;
            end else if (d_nan) begin
                d_sexp = EXP_NAN;
            end else if (mid_ok) begin
                d_sexp = m1;
            end else begin
                // Not mid-representable: replace with the canonical quiet NaN and flag it.
                d_nan    = 1'b1;
                d_snan   = 1'b0;
                d_sign   = 1'b0;
                d_sexp   = EXP_NAN;
                d_sig    = {2'b01, 1'b1, {(outSigWidth-2){1'b0}}};
                d_notmid = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed         <= 1'b0;
            v1            <= 1'b0;
            v2            <= 1'b0;
            p1            <= 1'b0;
            rec1          <= '0;
            out_precision <= 1'b0;
            out_isNaN     <= 1'b0;
            out_isSigNaN  <= 1'b0;
            out_isInf     <= 1'b0;
            out_isZero    <= 1'b0;
            out_sign      <= 1'b0;
            out_sExp      <= '0;
            out_sig       <= '0;
            out_notMid    <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (en1) begin
                v1 <= in_valid && in_ready;
                if (in_valid && in_ready) begin
                    p1   <= in_precision;
                    rec1 <= in_rec;
                end
            end
            if (en2) begin
                v2 <= v1;
                if (v1) begin
                    out_precision <= p1;
                    out_isNaN     <= d_nan;
                    out_isSigNaN  <= d_snan;
                    out_isInf     <= d_inf;
                    out_isZero    <= d_zero;
                    out_sign      <= d_sign;
                    out_sExp      <= d_sexp;
                    out_sig       <= d_sig;
                    out_notMid    <= d_notmid;
                end
            end
        end
    end
endmodule

// File: tb/tb_recfntorawfn_mixed.sv
// Randomized and directed bench for recfntorawfn_mixed against an arithmetic reference model and scoreboard.
module tb_recfntorawfn_mixed;
    typedef struct packed {
        logic        prec;
        logic        nan;
        logic        snan;
        logic        inf;
        logic        zero;
        logic        sign;
        logic [12:0] sexp;
        logic [53:0] sig;
        logic        notmid;
    } res_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_precision = 1'b0;
    logic [64:0] in_rec = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_precision;
    logic        out_isNaN;
    logic        out_isSigNaN;
    logic        out_isInf;
    logic        out_isZero;
    logic        out_sign;
    logic [12:0] out_sExp;
    logic [53:0] out_sig;
    logic        out_notMid;

    int   checks = 0;
    int   errors = 0;
    int   out_cnt = 0;
    res_t exp_q[$];
    res_t cur;
    res_t held;
    logic stalled = 1'b0;

    always #5 clock = ~clock;

    recfntorawfn_mixed dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_precision(in_precision), .in_rec(in_rec),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_precision(out_precision), .out_isNaN(out_isNaN),
        .out_isSigNaN(out_isSigNaN), .out_isInf(out_isInf),
        .out_isZero(out_isZero), .out_sign(out_sign),
        .out_sExp(out_sExp), .out_sig(out_sig), .out_notMid(out_notMid)
    );

    assign cur = {out_precision, out_isNaN, out_isSigNaN, out_isInf, out_isZero,
                  out_sign, out_sExp, out_sig, out_notMid};

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: classify by the top three exponent bits, rebias mid words by 2048-256.
    function automatic res_t model(input logic p, input logic [64:0] w);
        res_t        x;
        int          e;
        int          m;
        int          cls;
        logic [51:0] f;
        e   = int'(w[63:52]);
        f   = w[51:0];
        cls = e / 512;
        x        = '0;
        x.prec   = p;
        x.sign   = w[64];
        x.zero   = (cls == 0);
        x.inf    = (cls == 6);
        x.nan    = (cls == 7);
        x.snan   = x.nan && (f < (52'd1 << 51));
        x.sig    = {1'b0, !x.zero, f};
        if (p) begin
            x.sexp = 13'(e);
        end else if (x.zero) begin
            x.sexp = 13'd0;
        end else if (x.inf) begin
            x.sexp = 13'd384;
        end else if (x.nan) begin
            x.sexp = 13'd448;
        end else begin
            m = e - 1792;
            if ((f % (52'd1 << 29)) != 52'd0 || m < 107 || m > 383) begin
                x        = '0;
                x.nan    = 1'b1;
                x.notmid = 1'b1;
                x.sexp   = 13'd448;
                x.sig    = 54'd3 << 51;
            end else begin
                x.sexp = 13'(m);
            end
        end
        return x;
    endfunction

    function automatic logic [65:0] gen_word();
        logic        s;
        logic [11:0] e;
        logic [51:0] f;
        s = 1'($urandom_range(0, 1));
        f = 52'({$urandom, $urandom});
        case ($urandom_range(0, 5))
            0:       e = 12'($urandom_range(0, 511));
            1:       e = 12'($urandom_range(3072, 3583));
            2:       e = 12'($urandom_range(3584, 4095));
            3:       e = 12'($urandom_range(512, 3071));
            default: e = 12'(1792 + $urandom_range(100, 390));
        endcase
        if ($urandom_range(0, 1) == 1) f[28:0] = '0;
        return {1'($urandom_range(0, 1)), s, e, f};
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled && out_valid) check("hold", 80'(cur), 80'(held));
            stalled = out_valid && !out_ready;
            held    = cur;
            if (out_valid && out_ready) begin
                out_cnt++;
                check("out_expected", 80'(exp_q.size() != 0), 80'(1));
                if (exp_q.size() != 0) check("stream", 80'(cur), 80'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_precision, in_rec));
        end
    end

    task automatic send_one(input logic p, input logic [64:0] w, output res_t got);
        int n;
        in_valid     = 1'b1;
        in_precision = p;
        in_rec       = w;
        out_ready    = 1'b1;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("send_rdy", 80'(in_ready), 80'(1));
        @(posedge clock); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
        check("latency", 80'(n), 80'(2));
        got = cur;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("drain", 80'(exp_q.size()), 80'(0));
    endtask

    initial begin
        res_t        r;
        logic [65:0] words[8];
        logic [65:0] g;
        int          idx;
        int          cyc;
        int          base;
        int          sent;
        logic        pend;

        repeat (2) @(posedge clock);
        #1;
        check("rst_out", 80'(cur), 80'(0));
        check("rst_vld", 80'(out_valid), 80'(0));
        check("rst_rdy", 80'(in_ready), 80'(0));
        reset = 1'b0;
        @(negedge clock);
        check("rdy_delay", 80'(in_ready), 80'(0));
        @(posedge clock); #1;
        check("rdy_up", 80'(in_ready), 80'(1));

        send_one(1'b1, {1'b0, 12'h800, 52'h0}, r);
        check("full_sexp", 80'(r.sexp), 80'(2048));
        check("full_sig", 80'(r.sig), 80'(54'h10_0000_0000_0000));
        check("full_flags", 80'({r.nan, r.snan, r.inf, r.zero, r.notmid}), 80'(0));
        check("full_prec", 80'(r.prec), 80'(1));

        send_one(1'b0, {1'b0, 12'h800, 52'h0}, r);
        check("mid_sexp", 80'(r.sexp), 80'(256));
        check("mid_sig", 80'(r.sig), 80'(54'h10_0000_0000_0000));
        check("mid_notmid", 80'(r.notmid), 80'(0));

        send_one(1'b0, {1'b0, 12'h800, 52'h1}, r);
        check("inexact_class", 80'({r.nan, r.snan, r.sign, r.notmid}), 80'(4'b1001));
        check("inexact_sexp", 80'(r.sexp), 80'(448));

        send_one(1'b0, {1'b1, 12'hC00, 52'h0}, r);
        check("inf_class", 80'({r.inf, r.sign, r.notmid}), 80'(3'b110));
        check("inf_sexp", 80'(r.sexp), 80'(384));

        send_one(1'b0, {1'b0, 12'hE00, 52'h1}, r);
        check("snan_class", 80'({r.nan, r.snan}), 80'(2'b11));

        send_one(1'b0, {1'b0, 12'd1899, 52'h0}, r);
        check("lo_edge_ok", 80'({r.notmid, r.sexp}), 80'({1'b0, 13'd107}));
        send_one(1'b0, {1'b0, 12'd1898, 52'h0}, r);
        check("lo_edge_bad", 80'(r.notmid), 80'(1));
        send_one(1'b0, {1'b0, 12'd2175, 52'h0}, r);
        check("hi_edge_ok", 80'({r.notmid, r.sexp}), 80'({1'b0, 13'd383}));
        send_one(1'b0, {1'b0, 12'd2176, 52'h0}, r);
        check("hi_edge_bad", 80'(r.notmid), 80'(1));

        drain();
        for (int i = 0; i < 8; i++) words[i] = gen_word();
        base = out_cnt;
        idx  = 0;
        cyc  = 0;
        while (idx < 8 && cyc < 40) begin
            in_valid     = 1'b1;
            in_precision = words[idx][65];
            in_rec       = words[idx][64:0];
            out_ready    = !(cyc >= 3 && cyc <= 5);
            @(negedge clock);
            if (cyc >= 3 && cyc <= 5) check("stall_rdy", 80'(in_ready), 80'(0));
            if (in_ready) idx++;
            @(posedge clock); #1;
            cyc++;
        end
        drain();
        check("stream_cnt", 80'(out_cnt - base), 80'(8));

        sent = 0;
        pend = 1'b0;
        cyc  = 0;
        while (sent < 300 && cyc < 5000) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                g            = gen_word();
                in_precision = g[65];
                in_rec       = g[64:0];
                pend         = 1'b1;
            end
            in_valid  = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            if (in_valid && in_ready) begin
                sent++;
                pend = 1'b0;
            end
            @(posedge clock); #1;
            cyc++;
        end
        check("rand_sent", 80'(sent), 80'(300));
        drain();

        out_ready    = 1'b1;
        in_valid     = 1'b1;
        g            = gen_word();
        in_precision = g[65];
        in_rec       = g[64:0];
        @(posedge clock); #1;
        g            = gen_word();
        in_precision = g[65];
        in_rec       = g[64:0];
        @(posedge clock); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pre_rst_vld", 80'(out_valid), 80'(1));
        reset = 1'b1;
        #1;
        check("async_clear", 80'(out_valid), 80'(0));
        @(posedge clock); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        base      = out_cnt;
        repeat (4) begin
            @(negedge clock);
            check("dropped", 80'(out_valid), 80'(0));
        end
        @(posedge clock); #1;
        send_one(1'b0, {1'b1, 12'h800, 52'h0}, r);
        check("post_rst_sexp", 80'({r.sign, r.sexp}), 80'({1'b1, 13'd256}));
        drain();
        check("post_rst_cnt", 80'(out_cnt - base), 80'(1));
        check("leftover", 80'(exp_q.size()), 80'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/recfntorawfn_mixed.md
Name: recFNToRawFN_mixed

Overview:
- Pipelined unpacker from an out-format recoded float word into raw fields (isNaN/isInf/isZero/sign/sExp/sig), with per-operand precision.
- precision=0 means the word is an upconverted mid-format value. The block checks it is exactly mid-representable and rebiases the exponent back to mid.
- It is the inverse of the mixed-precision round/upconvert path. It sits at the operand-read side of mixed-precision FPU lanes, in front of the raw-input arithmetic units.
- Uses a valid/ready handshake and sustains full throughput.

Parameters:
- midExpWidth, 8, mid-precision exponent width.
- midSigWidth, 24, mid-precision significand width (including hidden bit).
- outExpWidth, 11, full/container exponent width.
- outSigWidth, 53, full/container significand width.
- Derived: biasAdj = (1<<outExpWidth) - (1<<midExpWidth), which is 1792 at defaults.
- Derived: padW = outSigWidth - midSigWidth.

Ports:
- clock  in  1  block clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input this cycle.
- in_precision  in  1  0 = mid, 1 = full.
- in_rec  in  outExpWidth+outSigWidth+1  recoded word: {sign, exp[outExpWidth:0], fract[outSigWidth-2:0]}.
- out_valid  out  1  output fields valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_precision  out  1  precision carried through the pipe.
- out_isNaN  out  1  result is NaN.
- out_isSigNaN  out  1  result is a signaling NaN.
- out_isInf  out  1  result is infinity.
- out_isZero  out  1  result is zero.
- out_sign  out  1  result sign.
- out_sExp  out  outExpWidth+2  signed raw exponent, biased in the selected precision.
- out_sig  out  outSigWidth+1  raw significand {1'b0, hidden, fract}.
- out_notMid  out  1  precision=0 word was not exactly mid-representable.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Reset clears both stage-valid bits and all output registers to 0, including out_valid. in_ready goes to 1 one cycle after reset deasserts.
- Reset mid-operation discards in-flight words; no output is produced for them.
- Pipeline: S1 registers {in_precision, in_rec}. S2 registers the decoded fields, which drive all out_* ports directly.
- Latency: 2 cycles from an in handshake to out_valid when out_ready=1.
- Enables: en2 = !v2 | out_ready; en1 = !v1 | en2; in_ready = en1 (combinational, no extra bubble). One word per cycle at steady state.
- Stalls: when out_ready=0 and both stages are full, in_ready=0 and all registers hold. The out_* fields must stay stable while out_valid=1 and out_ready=0.
- Simultaneous S2 drain and S1 fill in the same cycle is legal and loses nothing.
- Decode, from e = exp field and c = e[outExpWidth:outExpWidth-2]:
  - isZero = (c==3'b000); isInf = (c==3'b110); isNaN = (c==3'b111).
  - isSigNaN = isNaN & !fract[outSigWidth-2].
  - sign passes through.
  - sig = {1'b0, !isZero, fract}.
- Full precision (precision=1): sExp = {1'b0, e}; notMid = 0.
- Mid precision (precision=0):
  - Zero, Inf and NaN keep their class. Their sExp is forced to 0 for zero, (3<<(midExpWidth-1)) for Inf, and (7<<(midExpWidth-2)) for NaN.
  - For finite nonzero words, m = e - biasAdj. The word is valid iff fract[padW-1:0]==0 AND m lies in [(1<<(midExpWidth-1))+3-midSigWidth, (3<<(midExpWidth-1))-1].
  - If valid: sExp = m, notMid = 0.
  - If invalid: notMid = 1; output is canonical quiet NaN (isNaN=1, isSigNaN=0, sign=0, sExp = 7<<(midExpWidth-2), sig = {2'b01, 1'b1, 0...}). isInf and isZero are 0.
- Arithmetic: all exponent math is at outExpWidth+2 bits signed. The range test must not wrap.

Test Plan:
- Reset, then precision=1, in_rec={0,12'h800,52'h0} (1.0) -> after 2 cycles out_valid=1, sExp=2048, sig=54'h10_0000_0000_0000, notMid=0, all class flags 0.
- precision=0, same word -> sExp=256 (2048-1792), sig unchanged, notMid=0.
- precision=0, in_rec={0,12'h800,52'h1} -> isNaN=1, isSigNaN=0, sign=0, sExp=448, notMid=1.
- precision=0, exp=12'hC00 (Inf, sign=1) -> isInf=1, sign=1, sExp=384, notMid=0. Also precision=0, exp=12'hE00, fract MSB=0 -> isNaN=1, isSigNaN=1.
- Streaming: 8 back-to-back words with out_ready held 0 for cycles 3-5 -> in_ready falls when both stages are full; outputs hold stable during the stall; all 8 emerge in order with no loss or duplication.
- Assert reset with 2 words in flight -> out_valid drops immediately (async), both words are dropped, and the first post-reset word emerges 2 cycles after its handshake.
